pow_job_sched: RTL and testbench

Job scheduler that shares one `perf_sys` proof-of-work engine between two requesters. It accepts a job (12 header bytes plus a 16-bit target) from either requester under round-robin arbitration, then drives the engine's `start`/`target`/`block*` inputs. It captures the engine's 32-bit nonce on `finish` and returns it to the owning requester, with a timeout that aborts and clears the engine. It sits between the host-side job sources and `perf_sys` in the mining subsystem.

---
 rtl/pow_pkg.sv | 19 +
 rtl/pow_job_sched_if.sv | 37 +++
 rtl/pow_job_sched_rr_arb2.sv | 34 +++
 rtl/pow_job_sched.sv | 126 ++++++++++++
 tb/tb_pow_job_sched.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pow_pkg.sv
// Shared types and sizes for the proof-of-work job scheduler.
package pow_pkg;

    localparam int BLOCK_BYTES = 12;
    localparam int TARGET_W    = 16;
    localparam int NONCE_W     = 32;
    localparam int BLOCK_W     = 96;
    localparam int N_REQ       = 2;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_ABORT = 3'd3,
        S_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/pow_job_sched_if.sv
// Requester and engine-facing signals of the job scheduler.
// Handshake: a job transfers on a rising edge where req_valid[i] && req_ready[i];
// a result transfers on a rising edge where rsp_valid[i] && rsp_ready[i].
interface pow_job_sched_if;
    import pow_pkg::*;

    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ*BLOCK_W-1:0]  req_block;
    logic [N_REQ*TARGET_W-1:0] req_target;
    logic [BLOCK_W-1:0]        eng_block;
    logic [TARGET_W-1:0]       eng_target;
    logic                      eng_start;
    logic                      eng_clear;
    logic                      eng_finish;
    logic [NONCE_W-1:0]        eng_nonce;
    logic [N_REQ-1:0]          rsp_valid;
    logic [N_REQ-1:0]          rsp_ready;
    logic [NONCE_W-1:0]        rsp_nonce;
    logic                      rsp_timeout;
    logic                      busy;

    // Scheduler side.
    modport slave (
        input  req_valid, req_block, req_target, eng_finish, eng_nonce, rsp_ready,
        output req_ready, eng_block, eng_target, eng_start, eng_clear,
               rsp_valid, rsp_nonce, rsp_timeout, busy
    );

    // Requester/engine side.
    modport master (
        output req_valid, req_block, req_target, eng_finish, eng_nonce, rsp_ready,
        input  req_ready, eng_block, eng_target, eng_start, eng_clear,
               rsp_valid, rsp_nonce, rsp_timeout, busy
    );

endinterface

// File: rtl/pow_job_sched_rr_arb2.sv
// Two-requester round-robin grant; the requester that did not win last time
// takes priority when both are asking.
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last,
    output logic [1:0] grant,
    output logic       grant_idx
);

    // Combinational grant selection.
    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        case (req_valid)
            2'b01: begin
                grant     = 2'b01;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant     = 2'b10;
                grant_idx = 1'b1;
            end
            2'b11: begin
                grant_idx = ~last;
                grant     = last ? 2'b01 : 2'b10;
            end
            default: begin
                grant     = 2'b00;
                grant_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pow_job_sched.sv
// Shares one proof-of-work engine between two requesters: accepts a job,
// runs the engine, returns the nonce (or an abort after TIMEOUT run cycles).
module pow_job_sched
    import pow_pkg::*;
#(
    parameter logic [31:0] TIMEOUT = 32'd1048576
) (
    input  logic           clk,
    input  logic           reset,
    pow_job_sched_if.slave bus,
    output state_t         dbg_state
);

    state_t               state;
    state_t               state_nxt;
    logic                 last;
    logic                 owner;
    logic [1:0]           grant;
    logic                 grant_idx;
    logic                 accept;
    logic [BLOCK_W-1:0]   blk_q;
    logic [TARGET_W-1:0]  tgt_q;
    logic [31:0]          cnt;
    logic [NONCE_W-1:0]   nonce_q;
    logic                 tmo_q;

    rr_arb2 u_arb (
        .req_valid (bus.req_valid),
        .last      (last),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; finish is deliberately ignored in START to mask a
    // finish level left over from the previous job.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (|bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: state_nxt = S_RUN;
            S_RUN: begin
                if (bus.eng_finish)               state_nxt = S_RESP;
                else if (cnt == TIMEOUT - 32'd1)  state_nxt = S_ABORT;
            end
            S_ABORT: state_nxt = S_RESP;
            S_RESP: begin
                if (bus.rsp_ready[owner]) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; req_ready is held low while reset is asserted.
    always_comb begin
        bus.req_ready = 2'b00;
        bus.eng_start = 1'b0;
        bus.eng_clear = 1'b0;
        bus.rsp_valid = 2'b00;
        case (state)
            S_IDLE:  if (!reset) bus.req_ready = grant;
            S_START: bus.eng_start = 1'b1;
            S_RUN:   bus.eng_start = 1'b1;
            S_ABORT: bus.eng_clear = 1'b1;
            S_RESP:  bus.rsp_valid[owner] = 1'b1;
            default: bus.req_ready = 2'b00;
        endcase
    end

    assign bus.busy        = (state != S_IDLE);
    assign bus.eng_block   = blk_q;
    assign bus.eng_target  = tgt_q;
    assign bus.rsp_nonce   = nonce_q;
    assign bus.rsp_timeout = tmo_q;
    assign dbg_state       = state;

    // Job latch: block, target, owner and round-robin history on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_q <= '0;
            tgt_q <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else if (accept) begin
            blk_q <= grant_idx ? bus.req_block[2*BLOCK_W-1:BLOCK_W]
                               : bus.req_block[BLOCK_W-1:0];
            tgt_q <= grant_idx ? bus.req_target[2*TARGET_W-1:TARGET_W]
                               : bus.req_target[TARGET_W-1:0];
            owner <= grant_idx;
            last  <= grant_idx;
        end
    end

    // Run-cycle counter: cleared in START, counts every RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                cnt <= '0;
        else if (state == S_START) cnt <= '0;
        else if (state == S_RUN)   cnt <= cnt + 32'd1;
    end

    // Result capture: nonce on finish, zero plus timeout flag on abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nonce_q <= '0;
            tmo_q   <= 1'b0;
        end else if (state == S_RUN && bus.eng_finish) begin
            nonce_q <= bus.eng_nonce;
            tmo_q   <= 1'b0;
        end else if (state == S_ABORT) begin
            nonce_q <= '0;
            tmo_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pow_job_sched.sv
// Directed bench for pow_job_sched: one instance with the default timeout,
// one with TIMEOUT=16 for the abort and finish/timeout race cases.
module tb_pow_job_sched;
    import pow_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    state_t st0;
    state_t st1;

    pow_job_sched_if bus0 ();
    pow_job_sched_if bus1 ();

    pow_job_sched dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus0),
        .dbg_state (st0)
    );

    pow_job_sched #(.TIMEOUT(32'd16)) dut_to (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus1),
        .dbg_state (st1)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]   exp_q[$];
    logic [95:0]  blk0;
    logic [95:0]  blk1;
    logic         both_seen  = 1'b0;
    logic         ready_busy = 1'b0;
    logic         run_ok;
    logic         hold_ok;
    logic         clr_seen;
    logic [1:0]   exp_g;

    // Protocol monitor: req_ready one-hot and only when idle.
    always @(negedge clk) begin
        if (bus0.req_ready == 2'b11 || bus1.req_ready == 2'b11) both_seen = 1'b1;
        if ((|bus0.req_ready && bus0.busy) || (|bus1.req_ready && bus1.busy)) ready_busy = 1'b1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            blk0[8*k +: 8] = 8'(8'hA0 + k);
            blk1[8*k +: 8] = 8'(8'h50 + k);
        end
        bus0.req_valid = '0; bus0.rsp_ready = '0; bus0.eng_finish = 1'b0; bus0.eng_nonce = '0;
        bus1.req_valid = '0; bus1.rsp_ready = '0; bus1.eng_finish = 1'b0; bus1.eng_nonce = '0;
        bus0.req_block = {blk1, blk0}; bus0.req_target = {16'h1234, 16'h00FF};
        bus1.req_block = {blk1, blk0}; bus1.req_target = {16'h1234, 16'h00FF};
        repeat (3) tick();
        reset = 1'b0;
        #1;

        // Reset state.
        chk("rst_state", st0, S_IDLE);
        chk("rst_busy", bus0.busy, 1'b0);
        chk("rst_start", bus0.eng_start, 1'b0);
        chk("rst_clear", bus0.eng_clear, 1'b0);
        chk("rst_rsp_valid", bus0.rsp_valid, 2'b00);
        chk("rst_nonce", bus0.rsp_nonce, 32'h0);
        chk("rst_block", bus0.eng_block, 96'h0);
        chk("rst_target", bus0.eng_target, 16'h0);

        // Single job from requester 0, finish 40 cycles after START.
        bus0.req_valid = 2'b01;
        #1;
        chk("t1_ready", bus0.req_ready, 2'b01);
        tick();
        bus0.req_valid = 2'b00;
        chk("t1_state", st0, S_START);
        chk("t1_start", bus0.eng_start, 1'b1);
        chk("t1_block", bus0.eng_block, 96'hABAA_A9A8_A7A6_A5A4_A3A2_A1A0);
        chk("t1_byte11", bus0.eng_block[95:88], 8'hAB);
        chk("t1_target", bus0.eng_target, 16'h00FF);
        run_ok = 1'b1;
        repeat (40) begin
            tick();
            if (!bus0.eng_start || bus0.rsp_valid != 2'b00) run_ok = 1'b0;
        end
        chk("t1_run", run_ok, 1'b1);
        bus0.eng_finish = 1'b1;
        bus0.eng_nonce  = 32'h0000_1234;
        tick();
        chk("t1_rsp_valid", bus0.rsp_valid, 2'b01);
        chk("t1_nonce", bus0.rsp_nonce, 32'h0000_1234);
        chk("t1_timeout", bus0.rsp_timeout, 1'b0);
        chk("t1_start_off", bus0.eng_start, 1'b0);
        bus0.eng_finish = 1'b0;
        bus0.rsp_ready  = 2'b01;
        tick();
        bus0.rsp_ready = 2'b00;
        chk("t1_idle", bus0.busy, 1'b0);
        chk("t1_rsp_drop", bus0.rsp_valid, 2'b00);

        // Requester 1 job, then 10 cycles of response backpressure.
        bus0.req_valid = 2'b10;
        #1;
        chk("t2_ready", bus0.req_ready, 2'b10);
        tick();
        bus0.req_valid = 2'b00;
        chk("t2_target", bus0.eng_target, 16'h1234);
        chk("t2_block", bus0.eng_block, blk1);
        tick();
        bus0.eng_finish = 1'b1;
        bus0.eng_nonce  = 32'h00C0_FFEE;
        tick();
        bus0.eng_finish = 1'b0;
        bus0.eng_nonce  = 32'h0;
        chk("t2_rsp_valid", bus0.rsp_valid, 2'b10);
        bus0.req_valid = 2'b11;
        bus0.rsp_ready = 2'b01;
        hold_ok = 1'b1;
        repeat (10) begin
            tick();
            if (bus0.rsp_nonce != 32'h00C0_FFEE || bus0.rsp_valid != 2'b10 ||
                bus0.req_ready != 2'b00 || st0 != S_RESP) hold_ok = 1'b0;
        end
        chk("t2_hold", hold_ok, 1'b1);
        bus0.req_valid = 2'b00;
        bus0.rsp_ready = 2'b10;
        tick();
        bus0.rsp_ready = 2'b00;
        chk("t2_idle", st0, S_IDLE);

        // Contention: both requesters valid for four jobs.
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        bus0.req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            #1;
            exp_g = exp_q.pop_front();
            chk("t3_grant", bus0.req_ready, exp_g);
            tick();
            tick();
            bus0.eng_finish = 1'b1;
            bus0.eng_nonce  = 32'(32'h100 + j);
            tick();
            bus0.eng_finish = 1'b0;
            chk("t3_owner", bus0.rsp_valid, exp_g);
            chk("t3_nonce", bus0.rsp_nonce, 32'(32'h100 + j));
            bus0.rsp_ready = exp_g;
            tick();
            bus0.rsp_ready = 2'b00;
        end
        bus0.req_valid = 2'b00;

        // Stale finish held through START is ignored, captured in first RUN cycle.
        bus0.eng_finish = 1'b1;
        bus0.eng_nonce  = 32'hCAFE_0001;
        bus0.req_valid  = 2'b01;
        tick();
        bus0.req_valid = 2'b00;
        chk("t4_start_state", st0, S_START);
        chk("t4_ignored", bus0.rsp_valid, 2'b00);
        tick();
        chk("t4_run_state", st0, S_RUN);
        tick();
        chk("t4_rsp_valid", bus0.rsp_valid, 2'b01);
        chk("t4_nonce", bus0.rsp_nonce, 32'hCAFE_0001);
        bus0.eng_finish = 1'b0;
        bus0.rsp_ready  = 2'b01;
        tick();
        bus0.rsp_ready = 2'b00;

        // Reset during RUN drops the job; requester 0 wins first afterwards.
        bus0.req_valid = 2'b11;
        #1;
        chk("t5_grant", bus0.req_ready, 2'b10);
        tick();
        bus0.req_valid = 2'b00;
        tick();
        tick();
        chk("t5_run", st0, S_RUN);
        bus0.req_valid = 2'b11;
        #2;
        reset = 1'b1;
        #1;
        chk("t5_state", st0, S_IDLE);
        chk("t5_start", bus0.eng_start, 1'b0);
        chk("t5_busy", bus0.busy, 1'b0);
        chk("t5_block", bus0.eng_block, 96'h0);
        chk("t5_target", bus0.eng_target, 16'h0);
        chk("t5_nonce", bus0.rsp_nonce, 32'h0);
        chk("t5_ready", bus0.req_ready, 2'b00);
        reset = 1'b0;
        #1;
        chk("t5_regrant", bus0.req_ready, 2'b01);
        tick();
        bus0.req_valid = 2'b00;
        tick();
        bus0.eng_finish = 1'b1;
        bus0.eng_nonce  = 32'h5;
        tick();
        bus0.eng_finish = 1'b0;
        chk("t5_rsp_valid", bus0.rsp_valid, 2'b01);
        bus0.rsp_ready = 2'b01;
        tick();
        bus0.rsp_ready = 2'b00;

        // TIMEOUT=16: finish on the last RUN cycle wins over the timeout.
        bus1.req_valid = 2'b01;
        #1;
        chk("t6_ready", bus1.req_ready, 2'b01);
        tick();
        bus1.req_valid = 2'b00;
        clr_seen = 1'b0;
        repeat (16) begin
            tick();
            if (bus1.eng_clear) clr_seen = 1'b1;
        end
        bus1.eng_finish = 1'b1;
        bus1.eng_nonce  = 32'h0000_BEEF;
        tick();
        if (bus1.eng_clear) clr_seen = 1'b1;
        chk("t6_no_clear", clr_seen, 1'b0);
        chk("t6_state", st1, S_RESP);
        chk("t6_rsp_valid", bus1.rsp_valid, 2'b01);
        chk("t6_timeout", bus1.rsp_timeout, 1'b0);
        chk("t6_nonce", bus1.rsp_nonce, 32'h0000_BEEF);
        bus1.eng_finish = 1'b0;
        bus1.rsp_ready  = 2'b01;
        tick();
        bus1.rsp_ready = 2'b00;

        // TIMEOUT=16 with no finish: clear 17 cycles after START, then abort response.
        bus1.req_valid = 2'b10;
        tick();
        bus1.req_valid = 2'b00;
        clr_seen = 1'b0;
        repeat (16) begin
            tick();
            if (bus1.eng_clear) clr_seen = 1'b1;
        end
        chk("t7_early_clear", clr_seen, 1'b0);
        tick();
        chk("t7_clear", bus1.eng_clear, 1'b1);
        chk("t7_start_off", bus1.eng_start, 1'b0);
        chk("t7_state", st1, S_ABORT);
        tick();
        chk("t7_clear_off", bus1.eng_clear, 1'b0);
        chk("t7_rsp_valid", bus1.rsp_valid, 2'b10);
        chk("t7_timeout", bus1.rsp_timeout, 1'b1);
        chk("t7_nonce", bus1.rsp_nonce, 32'h0);
        bus1.rsp_ready = 2'b10;
        tick();
        bus1.rsp_ready = 2'b00;
        chk("t7_idle", st1, S_IDLE);

        // Protocol monitor results.
        chk("ready_both", both_seen, 1'b0);
        chk("ready_busy", ready_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
